// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction SRAM port, redirect from the core and
// the downstream valid/ready instruction channel.
interface if_fetch_stage_if;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ds_valid;
    logic        ds_ready;
    logic [31:0] ds_pc;
    logic [31:0] ds_inst;
    logic        ds_ade;

    modport master (
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_rdata,
        input  br_taken, br_target,
        output ds_valid, ds_pc, ds_inst, ds_ade,
        input  ds_ready
    );

    modport slave (
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        output inst_sram_rdata,
        output br_taken, br_target,
        input  ds_valid, ds_pc, ds_inst, ds_ade,
        output ds_ready
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, drives a 1-cycle-latency SRAM and
// buffers responses for decode. Optional misaligned-redirect fault: IF_ADE_CHECK_EN.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000,
    parameter int          DEPTH    = 2
) (
    input logic             clk,
    input logic             reset,
    if_fetch_stage_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic          halt;
    logic          fault_pending;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   buf_pc   [DEPTH];
    logic [31:0]   buf_inst [DEPTH];

    logic [31:0]   target;
    logic          ade_fault;
    logic          pop;
    logic          push;
    logic          issue;
    logic          room;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] limit;
    logic [31:0]   push_inst;

`ifdef IF_ADE_CHECK_EN
    logic          buf_ade [DEPTH];

    assign target    = bus.br_target;
    assign ade_fault = bus.br_taken & (bus.br_target[1:0] != 2'b00);
    assign bus.ds_ade = reset ? 1'b0 : buf_ade[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset && push)
            buf_ade[wr_ptr] <= fault_pending;
    end
`else
    logic unused_target_lsb;

    assign target            = {bus.br_target[31:2], 2'b00};
    assign ade_fault         = 1'b0;
    assign bus.ds_ade        = 1'b0;
    assign unused_target_lsb = ^bus.br_target[1:0];
`endif

    assign bus.inst_sram_we    = 1'b0;
    assign bus.inst_sram_wdata = 32'h0;

    assign bus.ds_valid = ~reset & (count != '0) & ~bus.br_taken;
    assign bus.ds_pc    = reset ? 32'h0 : buf_pc[rd_ptr];
    assign bus.ds_inst  = reset ? 32'h0 : buf_inst[rd_ptr];
    assign pop          = bus.ds_valid & bus.ds_ready;

    // count + inflight - pop < DEPTH, rearranged so nothing underflows
    assign occupancy = count + CW'(inflight);
    assign limit     = CW'(DEPTH) + CW'(pop);
    assign room      = occupancy < limit;

    assign issue = ~reset & (bus.br_taken ? ~ade_fault : (~halt & room));
    assign bus.inst_sram_en   = issue;
    assign bus.inst_sram_addr = bus.br_taken ? target : fetch_pc;

    // The stale response lands in the redirect cycle itself, so suppressing the
    // push there is all the dropping needed; the redirect's own request survives.
    assign push      = (inflight | fault_pending) & ~bus.br_taken;
    assign push_inst = fault_pending ? 32'h0 : bus.inst_sram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc      <= RESET_PC;
            req_pc        <= RESET_PC;
            inflight      <= 1'b0;
            halt          <= 1'b0;
            fault_pending <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else if (bus.br_taken) begin
            fetch_pc      <= target + 32'd4;
            req_pc        <= target;
            inflight      <= issue;
            halt          <= ade_fault;
            fault_pending <= ade_fault;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else begin
            inflight      <= issue;
            fault_pending <= 1'b0;
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            buf_pc[wr_ptr]   <= req_pc;
            buf_inst[wr_ptr] <= push_inst;
        end
    end
endmodule
